fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16: branch target buffer depth, a power of two from 4 to 64; IDX = log2(BTB_ENTRIES).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: advance enable; 0 = fetch stall.
REQ-006 SHALL have port mispredict, input, 1: execute-stage redirect request.
REQ-007 SHALL have port redirect_pc, input, 32: correct next fetch address when mispredict=1.
REQ-008 SHALL have port upd_valid, input, 1: resolved branch or jump update strobe from execute.
REQ-009 SHALL have port upd_pc, input, 32: address of the resolved instruction.
REQ-010 SHALL have port upd_taken, input, 1: resolved direction.
REQ-011 SHALL have port upd_target, input, 32: resolved taken target.
REQ-012 SHALL have port pc_out, output, 32: current fetch address to instruction memory.
REQ-013 SHALL have port pc4_out, output, 32: pc_out+4, to the IF/ID register.
REQ-014 SHALL have port prediction_out, output, 1: predicted-taken for pc_out, to the IF/ID register.
REQ-015 SHALL have port flush_out, output, 1: combinational copy of mispredict; kills the instruction in IF/ID.

Function
REQ-016 SHALL hold pc_out in a 32-bit register with bits [1:0] always 0.
REQ-017 SHALL compute pc4_out = pc_out + 4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 SHALL give each BTB entry a valid bit, a tag of pc[31:IDX+2], a target of bits [31:2], and a 2-bit saturating counter.
REQ-019 SHALL look up combinationally with index pc_out[IDX+1:2]; hit = valid and tag match.
REQ-020 SHALL drive prediction_out = hit and counter[1]; predicted target = {entry target, 2'b00}.
REQ-021 SHALL select the next PC by priority: rst=0 -> RESET_PC; else mispredict=1 -> {redirect_pc[31:2], 2'b00}, regardless of en; else en=0 -> hold; else prediction_out=1 -> predicted target; else pc4_out.
REQ-022 SHALL, on upd_valid=1 with upd_pc hitting, do the following at the clock edge: counter +1 saturating at 3 if upd_taken, -1 saturating at 0 if not; target overwritten with upd_target only if upd_taken.
REQ-023 SHALL, on upd_valid=1 with upd_pc missing and upd_taken=1, allocate the entry: valid=1, tag and target written, counter=2'b10.
REQ-024 SHALL NOT allocate on upd_valid=1 with a miss and upd_taken=0.
REQ-025 SHALL apply BTB updates independently of en and mispredict.
REQ-026 SHALL resolve a same-cycle lookup and update to the same index with the lookup using pre-update contents; the update becomes visible the next cycle.
REQ-027 SHALL ignore upd_pc[1:0], upd_target[1:0] and redirect_pc[1:0].

Reset
REQ-028 SHALL, while rst=0 at a clock edge, set pc_out=RESET_PC and clear all valid bits; all counters = 2'b01.
REQ-029 SHALL make reset override all other inputs, including upd_valid and mispredict; no BTB write occurs in a reset cycle.
REQ-030 SHALL, in the first cycle after reset, output pc4_out=RESET_PC+4 and prediction_out=0.

Verification
REQ-031 SHALL cover: reset, then en=1 for 4 cycles -> pc_out 0,4,8,C,10; prediction_out=0 throughout.
REQ-032 SHALL cover: en=0 for 3 cycles at pc_out=8 -> pc_out stays 8; then mispredict=1 with redirect_pc=0x40 while en=0 -> pc_out=0x40 next cycle; flush_out=1 during that cycle.
REQ-033 SHALL cover: upd_valid, upd_pc=0x10, taken, target 0x80 -> fetch at 0x10 gives prediction_out=1 and next pc_out=0x80.
REQ-034 SHALL cover: two not-taken updates to 0x10 (counter 2->1->0) -> prediction_out=0 at 0x10, next pc_out=0x14; a third update leaves counter at 0; with BTB_ENTRIES=16, a taken update at 0x50 replaces the 0x10 entry (same index 4).
REQ-035 SHALL cover: upd_valid at the index currently being fetched -> old prediction that cycle, new prediction the next; pc_out=0xFFFF_FFFC with en=1 and no hit -> pc_out=0.
REQ-036 SHALL cover: rst=0 asserted mid-run together with upd_valid and mispredict -> pc_out=RESET_PC; BTB empty; no predictions on later fetches.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with a direct-mapped branch target buffer.
// The BTB is read combinationally at the current fetch address to choose the
// next PC. Execute-stage resolutions train it one clock edge later. A
// mispredict redirect overrides both prediction and stall.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        prediction_out,
  output logic        flush_out
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  // Word-aligned PC: only bits [31:2] are stored, so bits [1:0] are always zero.
  logic [29:0] pc_q, pc_d;

  // BTB storage, one register set per entry so that reset can clear every entry at once.
  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [29:0]      tgt_q   [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];

  // Lookup side (fetch address).
  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [29:0]      pred_tgt;

  // Update side (resolved instruction from execute).
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic [1:0]       wr_ctr_d;

  // The two low address bits of these inputs do not matter for word-aligned fetch.
  logic unused_low_bits;
  assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0], redirect_pc[1:0]};

  assign pc_out    = {pc_q, 2'b00};
  assign pc4_out   = pc_out + 32'd4;
  assign flush_out = mispredict;

  // Combinational BTB read at the current fetch address.
  // It sees pre-update contents when an update targets the same entry.
  always_comb begin
    rd_idx         = pc_q[IDX-1:0];
    rd_tag         = pc_q[29:IDX];
    rd_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_tgt       = tgt_q[rd_idx];
    prediction_out = rd_hit && ctr_q[rd_idx][1];
  end

  // Decode the resolved branch against the BTB and form its trained counter value.
  always_comb begin
    wr_idx   = upd_pc[IDX+1:2];
    wr_tag   = upd_pc[31:IDX+2];
    wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_ctr_d = ctr_q[wr_idx];
    if (upd_taken) begin
      if (ctr_q[wr_idx] != 2'b11) wr_ctr_d = ctr_q[wr_idx] + 2'd1;
    end else begin
      if (ctr_q[wr_idx] != 2'b00) wr_ctr_d = ctr_q[wr_idx] - 2'd1;
    end
  end

  // Next-PC priority: redirect, then stall, then predicted target, then sequential.
  always_comb begin
    pc_d = pc4_out[31:2];
    if (mispredict) begin
      pc_d = redirect_pc[31:2];
    end else if (!en) begin
      pc_d = pc_q;
    end else if (prediction_out) begin
      pc_d = pred_tgt;
    end
  end

  // PC register. Reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC[31:2];
    end else begin
      pc_q <= pc_d;
    end
  end

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
    logic sel;
    assign sel = upd_valid && (wr_idx == IDX'(gi));

    // Entry training: a hit bumps the counter (and the target if taken).
    // A taken miss allocates the entry with a weakly-taken counter.
    // A not-taken miss leaves the entry alone.
    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q[gi] <= 1'b0;
        tag_q[gi]   <= '0;
        tgt_q[gi]   <= '0;
        ctr_q[gi]   <= 2'b01;
      end else if (sel) begin
        if (wr_hit) begin
          ctr_q[gi] <= wr_ctr_d;
          if (upd_taken) tgt_q[gi] <= upd_target[31:2];
        end else if (upd_taken) begin
          valid_q[gi] <= 1'b1;
          tag_q[gi]   <= wr_tag;
          tgt_q[gi]   <= upd_target[31:2];
          ctr_q[gi]   <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with the default parameters
// (RESET_PC=0, BTB_ENTRIES=16, index = pc[5:2]).
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        prediction_out;
  logic        flush_out;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .en(en), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .pc_out(pc_out),
    .pc4_out(pc4_out), .prediction_out(prediction_out), .flush_out(flush_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle redirect with en=0; the PC then holds at addr.
  task automatic redirect(input logic [31:0] addr);
    en = 1'b0; mispredict = 1'b1; redirect_pc = addr;
    step();
    mispredict = 1'b0;
  endtask

  // One-cycle BTB update strobe.
  task automatic btb_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    step();
    upd_valid = 1'b0;
  endtask

  // Visit addr and report whether it predicts, without advancing further.
  task automatic probe(input string tag, input logic [31:0] addr, input logic exp_pred);
    redirect(addr);
    check_eq(tag, {31'd0, prediction_out}, {31'd0, exp_pred});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mispredict = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    step(); step();
    check_eq("reset pc", pc_out, 32'h0);
    check_eq("reset pc4", pc4_out, 32'h4);
    check_eq("reset pred", {31'd0, prediction_out}, 32'h0);

    // Sequential fetch 0,4,8,C,10.
    rst = 1'b1; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("seq pc %0d", i), pc_out, 32'(i * 4));
      check_eq($sformatf("seq pred %0d", i), {31'd0, prediction_out}, 32'h0);
    end

    // Stall at 8, then redirect while stalled.
    rst = 1'b0; step(); rst = 1'b1;
    step(); step();
    check_eq("run to 8", pc_out, 32'h8);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall %0d", i), pc_out, 32'h8);
    end
    mispredict = 1'b1; redirect_pc = 32'h43;
    #1;
    check_eq("flush_out", {31'd0, flush_out}, 32'h1);
    step();
    mispredict = 1'b0;
    #1;
    check_eq("redirect pc", pc_out, 32'h40);
    check_eq("flush off", {31'd0, flush_out}, 32'h0);

    // Taken update allocates 0x10 -> 0x80.
    btb_upd(32'h10, 1'b1, 32'h80);
    probe("alloc pred", 32'h10, 1'b1);
    en = 1'b1; step(); en = 1'b0;
    check_eq("predicted jump", pc_out, 32'h80);
    check_eq("pc4 at 0x80", pc4_out, 32'h84);

    // Train down 2->1->0, then saturate at 0.
    btb_upd(32'h10, 1'b0, 32'h200);
    btb_upd(32'h10, 1'b0, 32'h200);
    probe("ctr0 pred", 32'h10, 1'b0);
    en = 1'b1; step(); en = 1'b0;
    check_eq("ctr0 seq", pc_out, 32'h14);
    btb_upd(32'h10, 1'b0, 32'h200);
    btb_upd(32'h10, 1'b1, 32'h90);
    probe("sat0 then +1", 32'h10, 1'b0);
    btb_upd(32'h10, 1'b1, 32'h90);
    probe("ctr2 pred", 32'h10, 1'b1);
    // Saturate at 3, then one not-taken leaves 2 (still taken, target kept).
    btb_upd(32'h10, 1'b1, 32'h90);
    btb_upd(32'h10, 1'b1, 32'h90);
    btb_upd(32'h10, 1'b0, 32'h200);
    probe("sat3 then -1", 32'h10, 1'b1);
    en = 1'b1; step(); en = 1'b0;
    check_eq("target kept on nt", pc_out, 32'h90);

    // 0x50 shares index 4 with 0x10 and replaces it.
    btb_upd(32'h50, 1'b1, 32'hA3);
    probe("evicted 0x10", 32'h10, 1'b0);
    probe("new 0x50", 32'h50, 1'b1);
    en = 1'b1; step(); en = 1'b0;
    check_eq("jump from 0x50", pc_out, 32'hA0);

    // A not-taken miss must not allocate.
    btb_upd(32'h22, 1'b0, 32'h300);
    probe("no alloc nt", 32'h20, 1'b0);

    // Same-cycle update at the fetched index: old value now, new value next cycle.
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h300;
    #1;
    check_eq("same-cycle old", {31'd0, prediction_out}, 32'h0);
    step();
    upd_valid = 1'b0;
    check_eq("same-cycle new", {31'd0, prediction_out}, 32'h1);
    en = 1'b1; step(); en = 1'b0;
    check_eq("jump from 0x20", pc_out, 32'h300);

    // Address wrap.
    redirect(32'hFFFF_FFFC);
    check_eq("wrap pc4", pc4_out, 32'h0);
    en = 1'b1; step(); en = 1'b0;
    check_eq("wrap pc", pc_out, 32'h0);

    // Mid-run reset beats update and mispredict.
    redirect(32'h100);
    rst = 1'b0; en = 1'b1; mispredict = 1'b1; redirect_pc = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1; upd_target = 32'h400;
    step();
    rst = 1'b1; mispredict = 1'b0; upd_valid = 1'b0; en = 1'b0;
    check_eq("midrst pc", pc_out, 32'h0);
    check_eq("midrst pred", {31'd0, prediction_out}, 32'h0);
    probe("midrst 0x10", 32'h10, 1'b0);
    probe("midrst 0x50", 32'h50, 1'b0);
    probe("midrst 0x20", 32'h20, 1'b0);
    probe("midrst 0x30", 32'h30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
